// File: rtl/hilo_unit.sv
// HI/LO special-register unit: one-entry pending write stage in front of the
// architectural HI/LO pair, with optional read forwarding of the pending entry.
module hilo_unit #(
  parameter int DW     = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [DW-1:0]   req_hi,
  input  logic [DW-1:0]   req_lo,
  output logic [2*DW-1:0] hilo_out,
  output logic            pend_valid,
  output logic            op_err
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MTHI = 3'b001;
  localparam logic [2:0] OP_MTLO = 3'b010;
  localparam logic [2:0] OP_WR   = 3'b011;
  localparam logic [2:0] OP_MADD = 3'b100;
  localparam logic [2:0] OP_MSUB = 3'b101;

  logic [DW-1:0]   arch_hi_q, arch_hi_d;
  logic [DW-1:0]   arch_lo_q, arch_lo_d;
  logic [2*DW-1:0] pend_val_q, pend_val_d;
  logic [1:0]      pend_mask_q, pend_mask_d;
  logic            pend_valid_q, pend_valid_d;
  logic            op_err_q, op_err_d;

  logic [DW-1:0]   fwd_hi, fwd_lo;
  logic [2*DW-1:0] fwd_val, req_val;
  logic [2*DW-1:0] cap_val;
  logic [1:0]      cap_mask;
  logic            op_known, advance, capture, commit;

  // Request handshake: a request is consumed on any edge where req_valid=1,
  // stall=0 and flush=0; there is no ready, so it is captured or dropped then.
  assign advance  = !stall && !flush;
  assign op_known = (req_op != OP_NOP) && (req_op[2:1] != 2'b11);
  assign capture  = req_valid && advance && op_known;
  assign commit   = pend_valid_q && advance;

  // Operand source for read-modify-write ops always sees the pending entry.
  always_comb begin
    fwd_hi = (pend_valid_q && pend_mask_q[1]) ? pend_val_q[2*DW-1:DW] : arch_hi_q;
    fwd_lo = (pend_valid_q && pend_mask_q[0]) ? pend_val_q[DW-1:0]    : arch_lo_q;
  end

  assign fwd_val = {fwd_hi, fwd_lo};
  assign req_val = {req_hi, req_lo};

  always_comb begin
    cap_val  = req_val;
    cap_mask = 2'b11;
    case (req_op)
      OP_MTHI: begin cap_val = {req_hi, fwd_lo}; cap_mask = 2'b10; end
      OP_MTLO: begin cap_val = {fwd_hi, req_lo}; cap_mask = 2'b01; end
      OP_WR:   cap_val = req_val;
      OP_MADD: cap_val = fwd_val + req_val;
      OP_MSUB: cap_val = fwd_val - req_val;
      default: cap_val = req_val;
    endcase
  end

  always_comb begin
    arch_hi_d    = arch_hi_q;
    arch_lo_d    = arch_lo_q;
    pend_val_d   = pend_val_q;
    pend_mask_d  = pend_mask_q;
    pend_valid_d = pend_valid_q;
    op_err_d     = req_valid && advance && (req_op[2:1] == 2'b11);
    if (commit) begin
      if (pend_mask_q[1]) arch_hi_d = pend_val_q[2*DW-1:DW];
      if (pend_mask_q[0]) arch_lo_d = pend_val_q[DW-1:0];
    end
    if (flush) begin
      pend_valid_d = 1'b0;
    end else if (!stall) begin
      if (capture) begin
        pend_val_d   = cap_val;
        pend_mask_d  = cap_mask;
        pend_valid_d = 1'b1;
      end else begin
        pend_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arch_hi_q    <= '0;
      arch_lo_q    <= '0;
      pend_val_q   <= '0;
      pend_mask_q  <= '0;
      pend_valid_q <= 1'b0;
      op_err_q     <= 1'b0;
    end else begin
      arch_hi_q    <= arch_hi_d;
      arch_lo_q    <= arch_lo_d;
      pend_val_q   <= pend_val_d;
      pend_mask_q  <= pend_mask_d;
      pend_valid_q <= pend_valid_d;
      op_err_q     <= op_err_d;
    end
  end

  assign hilo_out   = FWD_EN ? fwd_val : {arch_hi_q, arch_lo_q};
  assign pend_valid = pend_valid_q;
  assign op_err     = op_err_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: a forwarding instance and a non-forwarding
// instance share one stimulus stream; expected values are hand-computed.
module tb_hilo_unit;

  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            flush;
  logic            req_valid;
  logic [2:0]      req_op;
  logic [DW-1:0]   req_hi;
  logic [DW-1:0]   req_lo;
  logic [2*DW-1:0] hilo_out, hilo_out_nf;
  logic            pend_valid, pend_valid_nf;
  logic            op_err, op_err_nf;

  int total;
  int passed;

  hilo_unit #(.DW(DW), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_hi(req_hi), .req_lo(req_lo),
    .hilo_out(hilo_out), .pend_valid(pend_valid), .op_err(op_err)
  );

  hilo_unit #(.DW(DW), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_hi(req_hi), .req_lo(req_lo),
    .hilo_out(hilo_out_nf), .pend_valid(pend_valid_nf), .op_err(op_err_nf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drivers: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] hi,
                       input logic [31:0] lo);
    req_valid = v;
    req_op    = op;
    req_hi    = hi;
    req_lo    = lo;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    #2;
    chk("rst_hilo", hilo_out, 64'h0);
    chk("rst_pend", {63'b0, pend_valid}, 64'h0);
    chk("rst_err", {63'b0, op_err}, 64'h0);
    tick(); tick();
    rst = 1'b0;

    // WR forwarded from the cycle after capture, architectural one edge later
    drive(1'b1, 3'b011, 32'h1, 32'h2);
    tick(); idle();
    chk("wr_pend1", {63'b0, pend_valid}, 64'h1);
    chk("wr_fwd", hilo_out, 64'h00000001_00000002);
    chk("wr_nf_old", hilo_out_nf, 64'h0);
    tick();
    chk("wr_pend0", {63'b0, pend_valid}, 64'h0);
    chk("wr_arch", hilo_out_nf, 64'h00000001_00000002);

    // MADD chain through forwarding
    drive(1'b1, 3'b011, 32'h0, 32'hFFFF_FFFF);
    tick(); idle(); tick();
    drive(1'b1, 3'b100, 32'h0, 32'h1);
    tick();
    chk("madd1_fwd", hilo_out, 64'h00000001_00000000);
    chk("madd1_nf", hilo_out_nf, 64'h00000000_FFFFFFFF);
    tick(); idle();
    chk("madd2_fwd", hilo_out, 64'h00000001_00000001);
    chk("madd2_nf", hilo_out_nf, 64'h00000001_00000000);
    chk("madd2_pend", {63'b0, pend_valid}, 64'h1);
    tick();
    chk("madd_arch", hilo_out_nf, 64'h00000001_00000001);

    // MSUB wraps below zero
    drive(1'b1, 3'b011, 32'h0, 32'h0);
    tick(); idle(); tick();
    drive(1'b1, 3'b101, 32'h0, 32'h1);
    tick(); idle();
    chk("msub_fwd", hilo_out, 64'hFFFFFFFF_FFFFFFFF);
    tick();
    chk("msub_arch", hilo_out_nf, 64'hFFFFFFFF_FFFFFFFF);
    chk("msub_err", {63'b0, op_err}, 64'h0);

    // MTHI killed by flush; flushed request also discarded
    drive(1'b1, 3'b011, 32'hAAAA_AAAA, 32'h5555_5555);
    tick(); idle(); tick();
    drive(1'b1, 3'b001, 32'h1234, 32'hDEAD);
    tick(); idle();
    chk("mthi_fwd", hilo_out, 64'h00001234_55555555);
    flush = 1'b1;
    tick();
    chk("flush_pend", {63'b0, pend_valid}, 64'h0);
    chk("flush_hilo", hilo_out, 64'hAAAAAAAA_55555555);
    drive(1'b1, 3'b011, 32'h9, 32'h9);
    tick(); idle(); flush = 1'b0;
    chk("flush_req_pend", {63'b0, pend_valid}, 64'h0);
    chk("flush_req_hilo", hilo_out, 64'hAAAAAAAA_55555555);

    // MTLO held by stall; request during stall ignored
    drive(1'b1, 3'b010, 32'hBEEF, 32'h7);
    tick();
    chk("mtlo_fwd", hilo_out, 64'hAAAAAAAA_00000007);
    chk("mtlo_nf", hilo_out_nf, 64'hAAAAAAAA_55555555);
    stall = 1'b1;
    drive(1'b1, 3'b011, 32'h3, 32'h3);
    tick(); tick(); tick();
    chk("stall_pend", {63'b0, pend_valid}, 64'h1);
    chk("stall_nf", hilo_out_nf, 64'hAAAAAAAA_55555555);
    chk("stall_fwd", hilo_out, 64'hAAAAAAAA_00000007);
    stall = 1'b0; idle();
    tick();
    chk("unstall_pend", {63'b0, pend_valid}, 64'h0);
    chk("unstall_arch", hilo_out_nf, 64'hAAAAAAAA_00000007);

    // flush overrides stall
    drive(1'b1, 3'b001, 32'hBEEF, 32'h0);
    tick(); idle();
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    chk("flstall_pend", {63'b0, pend_valid}, 64'h0);
    chk("flstall_hilo", hilo_out, 64'hAAAAAAAA_00000007);

    // Reserved opcodes
    drive(1'b1, 3'b110, 32'h1, 32'h1);
    tick(); idle();
    chk("rsv_err1", {63'b0, op_err}, 64'h1);
    chk("rsv_nocap", {63'b0, pend_valid}, 64'h0);
    tick();
    chk("rsv_err0", {63'b0, op_err}, 64'h0);
    drive(1'b1, 3'b001, 32'h5, 32'h0);
    tick();
    drive(1'b1, 3'b111, 32'h8, 32'h8);
    tick(); idle();
    chk("rsv2_err", {63'b0, op_err}, 64'h1);
    chk("rsv2_pend", {63'b0, pend_valid}, 64'h0);
    chk("rsv2_commit", hilo_out_nf, 64'h00000005_00000007);
    tick();
    chk("rsv2_err0", {63'b0, op_err}, 64'h0);

    // Reset mid-pending clears everything at once
    drive(1'b1, 3'b011, 32'hF0, 32'hF1);
    tick(); idle();
    chk("pre_rst_pend", {63'b0, pend_valid}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_hilo", hilo_out, 64'h0);
    chk("mrst_nf", hilo_out_nf, 64'h0);
    chk("mrst_pend", {63'b0, pend_valid}, 64'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 3'b011, 32'h2, 32'h3);
    tick(); idle();
    chk("post_rst_cap", hilo_out, 64'h00000002_00000003);
    tick();
    chk("post_rst_arch", hilo_out_nf, 64'h00000002_00000003);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
